// File: rtl/rule_loader.sv
// Rule-table writer: turns a 32-bit framed word stream into packed rule_s records
// and issues one handshaked table write per rule; table_valid marks a clean frame.
package network_pkg;
  typedef struct packed {
    logic [7:0]  action;
    logic [7:0]  proto;
    logic [31:0] src_ip;
    logic [31:0] src_mask;
    logic [31:0] dst_ip;
    logic [31:0] dst_mask;
    logic [15:0] sport_lo;
    logic [15:0] sport_hi;
    logic [15:0] dport_lo;
    logic [15:0] dport_hi;
  } rule_s;
endpackage

module rule_loader
  import network_pkg::*;
#(
  parameter int unsigned NUM_RULES = 64,
  localparam int unsigned ADDR_W = $clog2(NUM_RULES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output rule_s             wr_rule,
  output logic              table_valid,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);
  localparam int unsigned RULE_W         = $bits(rule_s);
  localparam int unsigned WORDS_PER_RULE = (RULE_W + 31) / 32;
  localparam int unsigned CNT_W          = $clog2(WORDS_PER_RULE + 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_RANGE = 2'd1;
  localparam logic [1:0] ERR_SHORT = 2'd2;
  localparam logic [1:0] ERR_LONG  = 2'd3;

  typedef enum logic [1:0] {S_HDR, S_LOAD, S_WRITE, S_DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       remaining_q, remaining_d;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;
  logic [RULE_W-1:0] shreg_q, shreg_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  rule_s             wr_rule_q, wr_rule_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_valid_q, wr_valid_d;
  logic              table_valid_q, table_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              in_accept;
  logic [15:0]       hdr_base;
  logic [15:0]       hdr_count;
  logic [16:0]       hdr_end;
  logic [CNT_W-1:0]  cnt_inc;
  logic              final_rule;

  assign in_accept  = in_valid && in_ready_q;
  assign hdr_base   = in_data[31:16];
  assign hdr_count  = in_data[15:0];
  assign hdr_end    = 17'(hdr_base) + 17'(hdr_count);
  assign cnt_inc    = word_cnt_q + CNT_W'(1);
  assign final_rule = (remaining_q == 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_HDR;
      addr_q        <= '0;
      remaining_q   <= '0;
      word_cnt_q    <= '0;
      shreg_q       <= '0;
      wr_addr_q     <= '0;
      wr_rule_q     <= '0;
      in_ready_q    <= 1'b1;
      wr_valid_q    <= 1'b0;
      table_valid_q <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      word_cnt_q    <= word_cnt_d;
      shreg_q       <= shreg_d;
      wr_addr_q     <= wr_addr_d;
      wr_rule_q     <= wr_rule_d;
      in_ready_q    <= in_ready_d;
      wr_valid_q    <= wr_valid_d;
      table_valid_q <= table_valid_d;
      done_q        <= done_d;
      err_q         <= err_d;
      err_code_q    <= err_code_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    word_cnt_d    = word_cnt_q;
    shreg_d       = shreg_q;
    wr_addr_d     = wr_addr_q;
    wr_rule_d     = wr_rule_q;
    table_valid_d = table_valid_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;

    case (state_q)
      S_HDR: begin
        if (in_accept) begin
          table_valid_d = 1'b0;
          err_code_d    = ERR_NONE;
          if (hdr_count == 16'd0 || hdr_end > 17'(NUM_RULES)) begin
            err_code_d = ERR_RANGE;
            err_d      = 1'b1;
            state_d    = in_last ? S_HDR : S_DRAIN;
          end else if (in_last) begin
            err_code_d = ERR_SHORT;
            err_d      = 1'b1;
          end else begin
            addr_d      = ADDR_W'(hdr_base);
            remaining_d = hdr_count;
            word_cnt_d  = '0;
            state_d     = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (in_accept) begin
          shreg_d    = RULE_W'({shreg_q, in_data});
          word_cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(WORDS_PER_RULE)) begin
            word_cnt_d = '0;
            // in_last must coincide exactly with the last word of the last rule
            if (final_rule && !in_last) begin
              err_code_d = ERR_LONG;
              err_d      = 1'b1;
              state_d    = S_DRAIN;
            end else if (!final_rule && in_last) begin
              err_code_d = ERR_SHORT;
              err_d      = 1'b1;
              state_d    = S_HDR;
            end else begin
              wr_rule_d = rule_s'(shreg_d);
              wr_addr_d = addr_q;
              state_d   = S_WRITE;
            end
          end else if (in_last) begin
            err_code_d = ERR_SHORT;
            err_d      = 1'b1;
            state_d    = S_HDR;
          end
        end
      end
      S_WRITE: begin
        if (wr_ready) begin
          addr_d      = addr_q + ADDR_W'(1);
          remaining_d = remaining_q - 16'd1;
          if (!final_rule) begin
            state_d = S_LOAD;
          end else begin
            state_d       = S_HDR;
            table_valid_d = 1'b1;
            done_d        = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (in_accept && in_last) state_d = S_HDR;
      end
      default: state_d = S_HDR;
    endcase

    in_ready_d = (state_d != S_WRITE);
    wr_valid_d = (state_d == S_WRITE);
  end

  assign in_ready    = in_ready_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_rule     = wr_rule_q;
  assign table_valid = table_valid_q;
  assign done        = done_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
endmodule
